pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the five-stage MIPS core. Collects stall requests from the decode stage (load-use hazard) and the execute stage (multi-cycle ALU ops) and flush requests (exception/branch redirect). Produces the registered per-stage stall vector, flush strobe and redirect PC consumed by pc_reg, the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Also provides a stall watchdog and a stall-cycle performance counter.

Parameters:
LOAD_STALL_CYC, 1, bubble cycles inserted per decode stall pulse (>=1)
FLUSH_CYC, 1, cycles flush_o stays high per flush request (>=1)
MAX_STALL, 1024, consecutive stalled cycles that trip the watchdog
CNT_W, 11, width of internal down/consecutive counters (>= clog2(max(MAX_STALL, LOAD_STALL_CYC, FLUSH_CYC))+1)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stallreq_id_i  in  1  one-cycle pulse from decode: load-use hazard
stallreq_ex_i  in  1  level from execute: held high while multi-cycle op busy
flush_req_i  in  1  one-cycle pulse: redirect pipeline
new_pc_i  in  32  redirect target, valid with flush_req_i
stall_o  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold
flush_o  out  1  clear all pipeline registers
new_pc_o  out  32  redirect target for pc_reg, valid while flush_o=1
stall_timeout_o  out  1  sticky watchdog flag
stall_cnt_o  out  32  saturating count of cycles with stall_o != 0

Behaviour:
- Reset (rst=0, async): state RUN, stall_o=6'b000000, flush_o=0, new_pc_o=32'h0, stall_timeout_o=0, stall_cnt_o=0, all counters 0. Reset mid-stall or mid-flush aborts immediately.
- All inputs sampled at rising edge; all outputs registered (Moore on state). Latency request -> output = 1 cycle.
- Output decode: RUN 000000; ID_STALL 000111; EX_STALL 001111; FLUSH stall 000000, flush_o=1.
- Priority each edge: flush_req_i > stallreq_ex_i > stallreq_id_i.
- RUN: flush_req -> FLUSH, cnt=FLUSH_CYC-1, new_pc_o<=new_pc_i; else ex -> EX_STALL; else id -> ID_STALL, cnt=LOAD_STALL_CYC-1; else RUN.
- ID_STALL: flush_req -> FLUSH (stall aborted); else ex -> EX_STALL; else cnt==0 -> RUN; else cnt--. stallreq_id_i ignored (decode frozen).
- EX_STALL: flush_req -> FLUSH; else ex high -> stay; else id -> ID_STALL (cnt reload); else RUN.
- FLUSH: flush_req -> restart FLUSH, cnt reload, new_pc_o<=new_pc_i (latest target wins); else cnt==0 -> RUN; else cnt--. ex/id requests ignored in FLUSH; stallreq_ex_i still high at exit -> EX_STALL next edge per RUN rules (taken from FLUSH exit edge directly).
- new_pc_o holds last loaded value outside FLUSH; only loaded on accepted flush_req.
- Watchdog: consec counter +1 each edge where next state is ID_STALL/EX_STALL, cleared when next state RUN/FLUSH; when consec reaches MAX_STALL, stall_timeout_o<=1, stays until reset. consec saturates at MAX_STALL.
- stall_cnt_o: +1 each cycle the registered stall_o != 0; saturates at 32'hFFFFFFFF, no wrap.
- No combinational path input -> output.

Test Plan:
- Reset: drive rst=0 mid EX_STALL -> all outputs zero immediately (async), RUN after release; no output change until first request.
- Load-use: LOAD_STALL_CYC=2, pulse stallreq_id_i at edge N -> stall_o=000111 for cycles N+1, N+2, 000000 at N+3; stall_cnt_o=2.
- Multi-cycle: stallreq_ex_i high 5 edges -> stall_o=001111 exactly 5 cycles, one cycle delayed; id pulse on the last-low edge -> ID_STALL follows without gap.
- Flush priority: flush_req_i, stallreq_ex_i and stallreq_id_i together with new_pc_i=32'h0000_0100 -> flush_o=1, stall_o=0, new_pc_o=32'h100 for FLUSH_CYC cycles; flush during ID_STALL aborts stall next cycle.
- Back-to-back flush: FLUSH_CYC=3, second flush (32'h200) in flush cycle 2 -> flush_o high 3 further cycles, new_pc_o=32'h200.
- Watchdog/saturation: MAX_STALL=8, ex held 10 cycles -> stall_timeout_o rises after 8th stalled edge, stays after ex drops; preload stall_cnt_o near max (force) -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges decode/execute stall and flush requests
// into registered per-stage stall, flush strobe and redirect PC, plus watchdog and stall counter.
module pipe_ctrl #(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned FLUSH_CYC      = 1,
    parameter int unsigned MAX_STALL      = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        flush_req_i,
    input  logic [31:0] new_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ID_STALL = 2'd1,
        EX_STALL = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_STALL_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_C        = CNT_W'(MAX_STALL);

    state_t           state_q, state_d, run_state;
    logic [CNT_W-1:0] cnt_q, cnt_d, run_cnt;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             load_pc;
    logic [5:0]       stall_d;
    logic             flush_d;

    // Decisions taken from RUN, reused when a flush window expires.
    always_comb begin
        run_state = RUN;
        run_cnt   = cnt_q;
        if (stallreq_ex_i) begin
            run_state = EX_STALL;
        end else if (stallreq_id_i) begin
            run_state = ID_STALL;
            run_cnt   = LOAD_RELOAD;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_pc = 1'b0;
        if (flush_req_i) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
            load_pc = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    state_d = run_state;
                    cnt_d   = run_cnt;
                end
                ID_STALL: begin
                    if (stallreq_ex_i)     state_d = EX_STALL;
                    else if (cnt_q == '0)  state_d = RUN;
                    else                   cnt_d   = cnt_q - 1'b1;
                end
                EX_STALL: begin
                    state_d = run_state;
                    cnt_d   = run_cnt;
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = run_state;
                        cnt_d   = run_cnt;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_d = '0;
        flush_d = 1'b0;
        case (state_d)
            ID_STALL: stall_d = 6'b000111;
            EX_STALL: stall_d = 6'b001111;
            FLUSH:    flush_d = 1'b1;
            default:  stall_d = '0;
        endcase
    end

    always_comb begin
        consec_d = '0;
        if (state_d == ID_STALL || state_d == EX_STALL)
            consec_d = (consec_q == MAX_C) ? consec_q : consec_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            consec_q        <= '0;
            stall_o         <= '0;
            flush_o         <= 1'b0;
            new_pc_o        <= '0;
            stall_timeout_o <= 1'b0;
            stall_cnt_o     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
            stall_o  <= stall_d;
            flush_o  <= flush_d;
            if (load_pc)
                new_pc_o <= new_pc_i;
            if (consec_d == MAX_C)
                stall_timeout_o <= 1'b1;
            if (stall_o != '0 && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for request sequencing, hand-written
// sequences for watchdog, async reset and counter saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id_i, stallreq_ex_i, flush_req_i;
    logic [31:0] new_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_timeout_o;
    logic [31:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(
        .LOAD_STALL_CYC(2),
        .FLUSH_CYC     (3),
        .MAX_STALL     (8),
        .CNT_W         (11)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .flush_req_i    (flush_req_i),
        .new_pc_i       (new_pc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .stall_timeout_o(stall_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, ex, id;
        logic [31:0] pc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] npc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, ex, id, input logic [31:0] pc,
                       input logic [5:0] st, input logic f, input logic [31:0] npc, cnt);
        vec_t v;
        v.fl = fl; v.ex = ex; v.id = id; v.pc = pc;
        v.stall = st; v.flush = f; v.npc = npc; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, ex, id, input logic [31:0] pc);
        flush_req_i = fl; stallreq_ex_i = ex; stallreq_id_i = id; new_pc_i = pc;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_cnt;
        rst = 1'b0;
        drive(0, 0, 0, 32'h0);
        #2;
        chk("reset_stall", {26'b0, stall_o}, 32'h0);
        chk("reset_flush", {31'b0, flush_o}, 32'h0);
        chk("reset_pc", new_pc_o, 32'h0);
        chk("reset_cnt", stall_cnt_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        //   fl ex id pc            stall     f  npc           cnt
        add(0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        32'd0);
        add(0, 0, 1, 32'h0,        6'h07, 0, 32'h0,        32'd0);
        add(0, 0, 0, 32'h0,        6'h07, 0, 32'h0,        32'd1);
        add(0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        32'd2);
        add(0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        32'd2);
        add(0, 1, 0, 32'h0,        6'h0F, 0, 32'h0,        32'd2);
        add(0, 1, 0, 32'h0,        6'h0F, 0, 32'h0,        32'd3);
        add(0, 1, 0, 32'h0,        6'h0F, 0, 32'h0,        32'd4);
        add(0, 1, 0, 32'h0,        6'h0F, 0, 32'h0,        32'd5);
        add(0, 1, 0, 32'h0,        6'h0F, 0, 32'h0,        32'd6);
        add(0, 0, 1, 32'h0,        6'h07, 0, 32'h0,        32'd7);
        add(0, 0, 0, 32'h0,        6'h07, 0, 32'h0,        32'd8);
        add(0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        32'd9);
        add(1, 1, 1, 32'h100,      6'h00, 1, 32'h100,      32'd9);
        add(0, 1, 0, 32'hDEAD,     6'h00, 1, 32'h100,      32'd9);
        add(0, 0, 0, 32'h0,        6'h00, 1, 32'h100,      32'd9);
        add(0, 0, 0, 32'h0,        6'h00, 0, 32'h100,      32'd9);
        add(0, 0, 1, 32'h0,        6'h07, 0, 32'h100,      32'd9);
        add(1, 0, 0, 32'h180,      6'h00, 1, 32'h180,      32'd10);
        add(0, 0, 0, 32'h0,        6'h00, 1, 32'h180,      32'd10);
        add(1, 0, 0, 32'h200,      6'h00, 1, 32'h200,      32'd10);
        add(0, 0, 0, 32'h0,        6'h00, 1, 32'h200,      32'd10);
        add(0, 0, 0, 32'h0,        6'h00, 1, 32'h200,      32'd10);
        add(0, 1, 0, 32'h0,        6'h0F, 0, 32'h200,      32'd10);
        add(0, 0, 0, 32'h0,        6'h00, 0, 32'h200,      32'd11);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].ex, vecs[i].id, vecs[i].pc);
            step();
            chk($sformatf("v%0d_stall", i), {26'b0, stall_o}, {26'b0, vecs[i].stall});
            chk($sformatf("v%0d_flush", i), {31'b0, flush_o}, {31'b0, vecs[i].flush});
            chk($sformatf("v%0d_pc", i), new_pc_o, vecs[i].npc);
            chk($sformatf("v%0d_cnt", i), stall_cnt_o, vecs[i].cnt);
            chk($sformatf("v%0d_tmo", i), {31'b0, stall_timeout_o}, 32'h0);
        end

        // Watchdog: ten consecutive execute-stall edges, trip after the eighth.
        drive(0, 1, 0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("wd%0d_stall", k), {26'b0, stall_o}, 32'h0F);
            chk($sformatf("wd%0d_tmo", k), {31'b0, stall_timeout_o}, (k >= 8) ? 32'h1 : 32'h0);
        end
        drive(0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wd_sticky", {31'b0, stall_timeout_o}, 32'h1);
            chk("wd_run", {26'b0, stall_o}, 32'h0);
        end

        // Async reset in the middle of an execute stall.
        drive(0, 1, 0, 32'h0);
        step();
        chk("pre_rst_stall", {26'b0, stall_o}, 32'h0F);
        #1 rst = 1'b0;
        #1;
        chk("async_stall", {26'b0, stall_o}, 32'h0);
        chk("async_tmo", {31'b0, stall_timeout_o}, 32'h0);
        chk("async_pc", new_pc_o, 32'h0);
        chk("async_cnt", stall_cnt_o, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_stall", {26'b0, stall_o}, 32'h0);
            chk("post_rst_flush", {31'b0, flush_o}, 32'h0);
            chk("post_rst_cnt", stall_cnt_o, 32'h0);
        end

        // Saturation: preload near max, stall and expect it to stick at all-ones.
        force dut.stall_cnt_o = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt_o;
        exp_cnt = 32'hFFFF_FFFD;
        drive(0, 1, 0, 32'h0);
        step();
        chk("sat0", stall_cnt_o, exp_cnt);
        for (int k = 0; k < 4; k++) begin
            step();
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
            chk($sformatf("sat%0d", k + 1), stall_cnt_o, exp_cnt);
        end
        chk("sat_final", stall_cnt_o, 32'hFFFF_FFFF);
        drive(0, 0, 0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
